// File: rtl/ap_txn_profiler.sv
// ap_txn_profiler: watches an ap_ctrl_hs handshake, timestamps starts and
// dones, and queues one {id, latency, interval} record per transaction.
// Ports: clock, reset (async, active-high); ap_start/ap_ready/ap_done/
// ap_continue observed handshake; finish ends the window; rec_valid/
// rec_ready/rec_id/rec_latency/rec_interval drain the record FIFO;
// txn_count, overflow (sticky drop flag) and busy are status outputs.
// Define APTP_INTERVAL_EN to keep the interval field; otherwise it reads 0.
module ap_txn_profiler #(
    parameter int CNT_W       = 32,
    parameter int ID_W        = 8,
    parameter int DEPTH       = 8,
    parameter int OUTSTANDING = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    input  logic             ap_continue,
    input  logic             finish,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [ID_W-1:0]  rec_id,
    output logic [CNT_W-1:0] rec_latency,
    output logic [CNT_W-1:0] rec_interval,
    output logic [ID_W-1:0]  txn_count,
    output logic             overflow,
    output logic             busy
);

    localparam int QAW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int QCW = $clog2(OUTSTANDING + 1);
    localparam int FAW = $clog2(DEPTH);
    localparam int FCW = $clog2(DEPTH + 1);
    localparam logic [QAW-1:0] QLAST = QAW'(OUTSTANDING - 1);
    localparam logic [QCW-1:0] QFULL = QCW'(OUTSTANDING);
    localparam logic [FCW-1:0] FFULL = FCW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t state, state_nx;
    logic   run, active;

    logic [CNT_W-1:0] cyc;
    logic             armed;

    logic [CNT_W-1:0] ts_mem [OUTSTANDING];
    logic [QAW-1:0]   q_wr, q_rd;
    logic [QCW-1:0]   q_cnt, q_cnt_nx;
    logic             q_full, q_empty;

    logic [ID_W-1:0]  id_mem  [DEPTH];
    logic [CNT_W-1:0] lat_mem [DEPTH];
    logic [FAW-1:0]   f_wr, f_rd;
    logic [FCW-1:0]   f_cnt, f_cnt_nx;
    logic             f_full, f_push, f_pop;

    logic start_ev, done_ev, push_ts, pop_ts, q_wr_en, bypass, rec_gen;
    logic drop;
    logic [CNT_W-1:0] ts_sel, lat_val, int_val;

    function automatic logic [QAW-1:0] q_inc(input logic [QAW-1:0] p);
        return (p == QLAST) ? '0 : p + 1'b1;
    endfunction

    // FSM: state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // FSM: next state
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = RUN;
            RUN:     if (finish) state_nx = DRAIN;
            DRAIN:   if (q_empty) state_nx = STOP;
            STOP:    state_nx = STOP;
            default: state_nx = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        run    = 1'b0;
        active = 1'b0;
        unique case (state)
            RUN:     begin run = 1'b1; active = 1'b1; end
            DRAIN:   active = 1'b1;
            default: ;
        endcase
    end

    assign q_full  = (q_cnt == QFULL);
    assign q_empty = (q_cnt == '0);
    assign f_full  = (f_cnt == FFULL);

    assign start_ev = ap_start & armed & run;
    assign done_ev  = ap_done & ap_continue & active;
    assign push_ts  = start_ev & ~q_full;
    assign pop_ts   = done_ev & ~q_empty;
    // Start and done together on an empty queue: the start's timestamp
    // passes straight through without touching the queue.
    assign bypass   = done_ev & q_empty & push_ts;
    assign q_wr_en  = push_ts & ~bypass;
    assign rec_gen  = pop_ts | bypass;
    assign q_cnt_nx = q_cnt + QCW'(q_wr_en) - QCW'(pop_ts);

    assign ts_sel  = q_empty ? cyc : ts_mem[q_rd];
    assign lat_val = cyc - ts_sel;

    assign f_pop    = rec_valid & rec_ready;
    assign f_push   = rec_gen & (~f_full | f_pop);
    assign f_cnt_nx = f_cnt + FCW'(f_push) - FCW'(f_pop);

    assign drop = (start_ev & q_full)
                | (done_ev & q_empty & ~push_ts)
                | (rec_gen & f_full & ~f_pop);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cyc       <= '0;
            armed     <= 1'b1;
            txn_count <= '0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            if (active && cyc != '1) cyc <= cyc + 1'b1;
            if (ap_ready)      armed <= 1'b1;
            else if (start_ev) armed <= 1'b0;
            if (rec_gen) txn_count <= txn_count + 1'b1;
            if (drop)    overflow  <= 1'b1;
            busy <= (q_cnt_nx != '0);
        end
    end

    // Timestamp queue
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < OUTSTANDING; i++) ts_mem[i] <= '0;
            q_wr  <= '0;
            q_rd  <= '0;
            q_cnt <= '0;
        end else begin
            if (q_wr_en) begin
                ts_mem[q_wr] <= cyc;
                q_wr         <= q_inc(q_wr);
            end
            if (pop_ts) q_rd <= q_inc(q_rd);
            q_cnt <= q_cnt_nx;
        end
    end

    // Record FIFO
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                id_mem[i]  <= '0;
                lat_mem[i] <= '0;
            end
            f_wr  <= '0;
            f_rd  <= '0;
            f_cnt <= '0;
        end else begin
            if (f_push) begin
                id_mem[f_wr]  <= txn_count;
                lat_mem[f_wr] <= lat_val;
                f_wr          <= f_wr + 1'b1;
            end
            if (f_pop) f_rd <= f_rd + 1'b1;
            f_cnt <= f_cnt_nx;
        end
    end

`ifdef APTP_INTERVAL_EN
    logic [CNT_W-1:0] int_mem [DEPTH];
    logic [CNT_W-1:0] prev_ts;
    logic             have_prev;

    assign int_val = have_prev ? ts_sel - prev_ts : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) int_mem[i] <= '0;
            prev_ts   <= '0;
            have_prev <= 1'b0;
        end else begin
            if (f_push) int_mem[f_wr] <= int_val;
            if (rec_gen) begin
                prev_ts   <= ts_sel;
                have_prev <= 1'b1;
            end
        end
    end

    assign rec_interval = int_mem[f_rd];
`else
    assign int_val      = '0;
    assign rec_interval = int_val;
`endif

    assign rec_valid   = (f_cnt != '0);
    assign rec_id      = id_mem[f_rd];
    assign rec_latency = lat_mem[f_rd];

endmodule

// File: tb/tb_ap_txn_profiler.sv
// tb_ap_txn_profiler: directed vectors with hand-computed records.
// Drives the handshake one cycle per step and drains the record FIFO.
module tb_ap_txn_profiler;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ap_start = 1'b0;
    logic        ap_ready = 1'b0;
    logic        ap_done = 1'b0;
    logic        ap_continue = 1'b1;
    logic        finish = 1'b0;
    logic        rec_valid;
    logic        rec_ready = 1'b0;
    logic [7:0]  rec_id;
    logic [31:0] rec_latency;
    logic [31:0] rec_interval;
    logic [7:0]  txn_count;
    logic        overflow;
    logic        busy;

    int checks = 0;
    int errors = 0;

`ifdef APTP_INTERVAL_EN
    localparam bit IEN = 1'b1;
`else
    localparam bit IEN = 1'b0;
`endif

    ap_txn_profiler dut (
        .clock        (clock),
        .reset        (reset),
        .ap_start     (ap_start),
        .ap_ready     (ap_ready),
        .ap_done      (ap_done),
        .ap_continue  (ap_continue),
        .finish       (finish),
        .rec_valid    (rec_valid),
        .rec_ready    (rec_ready),
        .rec_id       (rec_id),
        .rec_latency  (rec_latency),
        .rec_interval (rec_interval),
        .txn_count    (txn_count),
        .overflow     (overflow),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic step(input logic s, input logic d);
        ap_start = s;
        ap_ready = s;
        ap_done  = d;
        tick();
        ap_start = 1'b0;
        ap_ready = 1'b0;
        ap_done  = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input int id, input int lat,
                           input int iv);
        chk({tag, "_v"},   64'(rec_valid), 64'd1);
        chk({tag, "_id"},  64'(rec_id), 64'(id));
        chk({tag, "_lat"}, 64'(rec_latency), 64'(lat));
        chk({tag, "_int"}, 64'(rec_interval), IEN ? 64'(iv) : 64'd0);
        rec_ready = 1'b1;
        tick();
        rec_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        ap_start  = 1'b0;
        ap_ready  = 1'b0;
        ap_done   = 1'b0;
        finish    = 1'b0;
        rec_ready = 1'b0;
        idle(2);
        reset = 1'b0;
        tick();
    endtask

    initial begin
        // Reset state
        idle(2);
        chk("rst_valid", 64'(rec_valid), 64'd0);
        chk("rst_txn",   64'(txn_count), 64'd0);
        chk("rst_ovf",   64'(overflow), 64'd0);
        chk("rst_busy",  64'(busy), 64'd0);
        chk("rst_id",    64'(rec_id), 64'd0);
        chk("rst_lat",   64'(rec_latency), 64'd0);
        chk("rst_int",   64'(rec_interval), 64'd0);
        reset = 1'b0;
        tick();

        // Single transaction, latency 12
        step(1'b1, 1'b0);
        chk("t1_busy0", 64'(busy), 64'd1);
        idle(11);
        chk("t1_busy1", 64'(busy), 64'd1);
        step(1'b0, 1'b1);
        chk("t1_txn",  64'(txn_count), 64'd1);
        chk("t1_busy2", 64'(busy), 64'd0);
        pop_chk("t1", 0, 12, 0);
        chk("t1_empty", 64'(rec_valid), 64'd0);

        // Pipelined overlap
        do_reset();
        for (int t = 0; t <= 28; t++)
            step(t == 0 || t == 4 || t == 8, t == 20 || t == 24 || t == 28);
        chk("t2_txn", 64'(txn_count), 64'd3);
        pop_chk("t2a", 0, 20, 0);
        pop_chk("t2b", 1, 20, 4);
        pop_chk("t2c", 2, 20, 4);

        // Backpressure: 9 records into 8 entries
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b1);
            if (i == 7) chk("t3_ovf0", 64'(overflow), 64'd0);
        end
        chk("t3_ovf", 64'(overflow), 64'd1);
        chk("t3_txn", 64'(txn_count), 64'd9);
        for (int i = 0; i < 8; i++)
            pop_chk($sformatf("t3_%0d", i), i, 1, (i == 0) ? 0 : 2);
        chk("t3_empty", 64'(rec_valid), 64'd0);

        // Timestamp queue overflow
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0);
            if (i == 3) chk("t4_ovf0", 64'(overflow), 64'd0);
        end
        chk("t4_ovf", 64'(overflow), 64'd1);
        chk("t4_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
        chk("t4_busy0", 64'(busy), 64'd0);
        chk("t4_txn", 64'(txn_count), 64'd4);
        for (int i = 0; i < 4; i++)
            pop_chk($sformatf("t4_%0d", i), i, 5, (i == 0) ? 0 : 1);

        // Same-cycle start/done, held start, empty done
        do_reset();
        step(1'b1, 1'b1);
        chk("t5_txn0", 64'(txn_count), 64'd1);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_ovf0", 64'(overflow), 64'd0);
        pop_chk("t5a", 0, 0, 0);
        ap_start = 1'b1;
        idle(3);
        ap_ready = 1'b1;
        tick();
        ap_start = 1'b0;
        ap_ready = 1'b0;
        step(1'b0, 1'b1);
        chk("t5_txn1", 64'(txn_count), 64'd2);
        chk("t5_ovf1", 64'(overflow), 64'd0);
        pop_chk("t5b", 1, 4, 2);
        step(1'b0, 1'b1);
        chk("t5_ovf2", 64'(overflow), 64'd1);
        chk("t5_txn2", 64'(txn_count), 64'd2);
        chk("t5_none", 64'(rec_valid), 64'd0);

        // Finish and drain
        do_reset();
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        finish = 1'b1;
        tick();
        finish = 1'b0;
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        idle(1);
        chk("t6_stop", 64'(dut.state), 64'd3);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        chk("t6_txn", 64'(txn_count), 64'd2);
        chk("t6_ovf", 64'(overflow), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        pop_chk("t6a", 0, 4, 0);
        pop_chk("t6b", 1, 4, 1);
        chk("t6_empty", 64'(rec_valid), 64'd0);

        // Asynchronous reset mid-run
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b1);
        end
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        chk("t7_valid1", 64'(rec_valid), 64'd1);
        chk("t7_txn1",   64'(txn_count), 64'd3);
        chk("t7_ovf1",   64'(overflow), 64'd1);
        chk("t7_busy1",  64'(busy), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("t7_valid0", 64'(rec_valid), 64'd0);
        chk("t7_txn0",   64'(txn_count), 64'd0);
        chk("t7_ovf0",   64'(overflow), 64'd0);
        chk("t7_busy0",  64'(busy), 64'd0);
        tick();
        reset = 1'b0;
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ap_txn_profiler.md
# ap_txn_profiler

Synthesizable transaction profiler that sits directly downstream of an HLS-generated block's `ap_ctrl_hs` handshake (`ap_start`/`ap_ready`/`ap_done`/`ap_continue`) and consumes it. It timestamps every accepted start and completed done, and produces one latency/interval record per transaction into an internal FIFO. Software or a testbench drains the FIFO through a valid/ready port. It is the hardware counterpart of the module-status monitoring used in simulation, so the FIR top can be profiled on silicon.

## Interface
- `CNT_W`, 32: cycle counter and record field width.
- `ID_W`, 8: transaction index width; wraps modulo 2^ID_W.
- `DEPTH`, 8: record FIFO entries; power of two, ≥2.
- `OUTSTANDING`, 4: start-timestamp queue entries; power of two, ≥1.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `ap_start`  in  1  observed block start.
- `ap_ready`  in  1  observed block ready.
- `ap_done`  in  1  observed block done.
- `ap_continue`  in  1  observed continue; tie 1 when unused.
- `finish`  in  1  end of profiling window.
- `rec_valid`  out  1  record available.
- `rec_ready`  in  1  record consumed when high with `rec_valid`.
- `rec_id`  out  ID_W  transaction index.
- `rec_latency`  out  CNT_W  done cycle − start cycle.
- `rec_interval`  out  CNT_W  this start − previous start.
- `txn_count`  out  ID_W  completed transactions.
- `overflow`  out  1  sticky; a record or timestamp was dropped.
- `busy`  out  1  at least one start is outstanding.

## Operation
- Reset values: all outputs 0; FSM in IDLE; counters, queues, and FIFO empty.
- FSM:
  - IDLE → RUN on the first cycle after reset is deasserted.
  - RUN → DRAIN when `finish`=1.
  - DRAIN → STOP when the timestamp queue is empty.
  - STOP is terminal until reset.
- `cyc` increments every cycle in RUN and DRAIN. It saturates at all-ones and holds in STOP.
- Start event: `ap_start`=1 with `start_armed`=1, in RUN only.
  - `start_armed` clears on a start event and sets again on the cycle `ap_ready`=1.
  - A start event pushes `cyc` into the timestamp queue and stores it as `last_start`.
  - If the queue is full, the start is dropped and `overflow` sets.
- Done event: `ap_done`=1 and `ap_continue`=1, in RUN or DRAIN.
  - A done event pops the oldest timestamp `ts`.
  - It forms the record {`rec_id`=`txn_count`, `latency`=`cyc`−`ts`, `interval`=`ts`−`prev_ts`}, where `prev_ts` is the previous popped timestamp.
  - For the first record, `interval`=0.
  - It increments `txn_count` and pushes the record into the FIFO.
  - A done event with an empty queue produces no record and sets `overflow`.
- FIFO behaviour:
  - Push while full: the record is dropped, `overflow` sets, and `txn_count` still increments.
  - Simultaneous push and pop while full: the pop takes effect first and the push succeeds.
- Arithmetic: subtractions are unsigned modulo 2^CNT_W. No subtraction can go negative, because `cyc` saturates rather than wraps.
- Start and done in the same cycle with an empty queue: the start pushes first, then the done pops it, giving `latency`=0.
- Reset mid-operation clears everything asynchronously, including FIFO contents and `overflow`.

## Timing
- A record is visible on `rec_*` with `rec_valid`=1 one cycle after its done event, when the FIFO was empty.
- `rec_*` holds stable while `rec_valid`=1 and `rec_ready`=0.
- `busy`, `txn_count`, and `overflow` are registered and update one cycle after the event.
- Throughput: one start and one done accepted per cycle; one record popped per cycle.
- Latency convention: a done one cycle after its start gives `rec_latency`=1.

## Configuration
- `APTP_INTERVAL_EN` defined: `last_start`/`prev_ts` registers and the interval FIFO field exist, and `rec_interval` behaves as described above.
- Not defined: that logic is removed, the FIFO width shrinks by CNT_W, and `rec_interval` is constant 0.

## Test plan
- Single transaction:
  - Stimulus: after reset, start at cycle 5, `ap_ready` at 5, `ap_done` at 17, `rec_ready`=1.
  - Required: one record {id 0, latency 12, interval 0}; `txn_count`=1; `busy` high from cycle 6 to cycle 18.
- Pipelined overlap:
  - Stimulus: starts at cycles 10, 14, 18; dones at 30, 34, 38.
  - Required: three records with latencies 20, 20, 20 and intervals 0, 4, 4 (0 for every record without `APTP_INTERVAL_EN`).
- Backpressure:
  - Stimulus: `rec_ready`=0, 9 transactions with DEPTH=8.
  - Required: 8 records retained, `overflow`=1, `txn_count`=9. Then raise `rec_ready`: ids 0–7 drain in order.
- Timestamp overflow:
  - Stimulus: 5 starts with no done, OUTSTANDING=4.
  - Required: the 5th start is dropped, `overflow`=1. Then 4 dones give 4 records; `busy`=0 afterwards.
- Finish and drain:
  - Stimulus: `finish` while 2 transactions are outstanding, then 1 new `ap_start`, then 2 dones.
  - Required: the new start is ignored, 2 records are produced, the FSM reaches STOP, and `cyc` freezes.
- Asynchronous reset mid-run:
  - Stimulus: assert `reset` between clock edges with 3 records queued.
  - Required: `rec_valid`, `txn_count`, `overflow`, and `busy` go to 0 immediately, without waiting for an edge.
